// File: rtl/addsub_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_acc_ctrl_pkg
// Brief    : Opcode and state encodings shared by the adder sequencing stage.
// Revision : 1.0
// ============================================================================
package addsub_acc_ctrl_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ADD and SUB are the only commands that go through the external adder.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : addsub_acc_ctrl
// Brief    : Handshaked LOAD/ADD/SUB/CLR sequencer around an external adder.
// Revision : 1.0
// ============================================================================
module addsub_acc_ctrl
    import addsub_acc_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             m_o,
    input  logic [WIDTH-1:0] s_i,
    input  logic             co_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_v,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             res_valid
);

    localparam int                SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0]  SET_INIT = SET_W'(SETTLE_CYC - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_capture;
    logic [SET_W-1:0]  r_settle;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_m;
    logic              r_flag_c;
    logic              r_flag_v;
    logic [CNT_W-1:0]  r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    w_accept = 1'b1;
                    w_next   = is_arith(op) ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                if (r_settle == '0) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Adder operand registers move only on an arithmetic accept, so the
    // external adder sees stable inputs for the whole settle window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_m       <= 1'b0;
            r_flag_c  <= 1'b0;
            r_flag_v  <= 1'b0;
            r_ovf_cnt <= '0;
            r_settle  <= '0;
        end else begin
            if (w_accept) begin
                case (op)
                    OP_LOAD: r_acc <= din;
                    OP_CLR: begin
                        r_acc    <= '0;
                        r_flag_c <= 1'b0;
                        r_flag_v <= 1'b0;
                    end
                    default: begin
                        r_a      <= r_acc;
                        r_b      <= din;
                        r_m      <= op[1];
                        r_settle <= SET_INIT;
                    end
                endcase
            end
            if (r_state == ST_EXEC && r_settle != '0) begin
                r_settle <= r_settle - SET_W'(1);
            end
            if (w_capture) begin
                r_acc    <= s_i;
                r_flag_c <= co_i;
                r_flag_v <= v_i;
                if (v_i && (r_ovf_cnt != '1)) begin
                    r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign op_ready  = (r_state == ST_IDLE);
    assign res_valid = (r_state == ST_DONE);
    assign a_o       = r_a;
    assign b_o       = r_b;
    assign m_o       = r_m;
    assign acc       = r_acc;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    assign ovf_cnt   = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_addsub_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_acc_ctrl
// Brief    : Scoreboard bench for addsub_acc_ctrl wired to a 4-bit adder/subtractor.
// Revision : 1.0
// ============================================================================
module tb_addsub_acc_ctrl;

    localparam int W     = 4;
    localparam int CW    = 4;
    localparam int SET1  = 1;
    localparam int SET2  = 3;

    localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  din;
    logic [1:0]    op;
    logic          op_valid;
    logic          op_ready;
    logic [W-1:0]  a1, b1, s1, acc1;
    logic          m1, co1, v1, fc1, fv1, rv1;
    logic [CW-1:0] ovf1;

    logic [W-1:0]  din2;
    logic [1:0]    op2;
    logic          op_valid2;
    logic          op_ready2;
    logic [W-1:0]  a2, b2, s2, acc2;
    logic          m2, co2, v2, fc2, fv2, rv2;
    logic [CW-1:0] ovf2;

    // The existing combinational adder/subtractor: A + (B xor M) + M.
    logic [W:0] sum1, sum2;
    logic [W-1:0] bx1, bx2;
    assign bx1  = b1 ^ {W{m1}};
    assign sum1 = {1'b0, a1} + {1'b0, bx1} + {{W{1'b0}}, m1};
    assign s1   = sum1[W-1:0];
    assign co1  = sum1[W];
    assign v1   = (a1[W-1] == bx1[W-1]) && (s1[W-1] != a1[W-1]);
    assign bx2  = b2 ^ {W{m2}};
    assign sum2 = {1'b0, a2} + {1'b0, bx2} + {{W{1'b0}}, m2};
    assign s2   = sum2[W-1:0];
    assign co2  = sum2[W];
    assign v2   = (a2[W-1] == bx2[W-1]) && (s2[W-1] != a2[W-1]);

    addsub_acc_ctrl #(.WIDTH(W), .SETTLE_CYC(SET1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .op(op), .op_valid(op_valid),
        .op_ready(op_ready), .a_o(a1), .b_o(b1), .m_o(m1), .s_i(s1),
        .co_i(co1), .v_i(v1), .acc(acc1), .flag_c(fc1), .flag_v(fv1),
        .ovf_cnt(ovf1), .res_valid(rv1)
    );

    addsub_acc_ctrl #(.WIDTH(W), .SETTLE_CYC(SET2), .CNT_W(CW)) dut_slow (
        .clk(clk), .rst(rst), .din(din2), .op(op2), .op_valid(op_valid2),
        .op_ready(op_ready2), .a_o(a2), .b_o(b2), .m_o(m2), .s_i(s2),
        .co_i(co2), .v_i(v2), .acc(acc2), .flag_c(fc2), .flag_v(fv2),
        .ovf_cnt(ovf2), .res_valid(rv2)
    );

    typedef struct {
        logic [1:0] op;
        int acc, c, v, ovf, a, b, cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_acc, m_c, m_v, m_ovf;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_c = 0; m_v = 0; m_ovf = 0;
        sbq.delete();
    endtask

    // Reference: plain integer arithmetic on the accumulator value.
    task automatic model_push(input logic [1:0] o, input int d, input int accept_edge);
        exp_t e;
        int sr;
        e.op = o; e.a = m_acc; e.b = d;
        case (o)
            LD: m_acc = d;
            CL: begin m_acc = 0; m_c = 0; m_v = 0; end
            AD: begin
                m_c   = (m_acc + d > 15) ? 1 : 0;
                sr    = sx(m_acc) + sx(d);
                m_v   = (sr > 7 || sr < -8) ? 1 : 0;
                m_acc = (m_acc + d) % 16;
            end
            default: begin
                m_c   = (m_acc >= d) ? 1 : 0;
                sr    = sx(m_acc) - sx(d);
                m_v   = (sr > 7 || sr < -8) ? 1 : 0;
                m_acc = (m_acc - d + 16) % 16;
            end
        endcase
        if ((o == AD || o == SB) && m_v == 1 && m_ovf < 15) m_ovf++;
        e.acc = m_acc; e.c = m_c; e.v = m_v; e.ovf = m_ovf;
        e.cyc = accept_edge + ((o == AD || o == SB) ? SET1 : 0);
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && rv1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_res_valid", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("acc", acc1, mon_e.acc);
                chk("flag_c", fc1, mon_e.c);
                chk("flag_v", fv1, mon_e.v);
                chk("ovf_cnt", ovf1, mon_e.ovf);
                chk("res_latency", cyc, mon_e.cyc);
                if (mon_e.op == AD || mon_e.op == SB) begin
                    chk("a_o", a1, mon_e.a);
                    chk("b_o", b1, mon_e.b);
                    chk("m_o", m1, (mon_e.op == SB) ? 1 : 0);
                end
            end
        end
    end

    // Issue one command; optionally keep op_valid high with another op while busy.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] d, input bit hold);
        int n;
        @(negedge clk);
        op = o; din = d; op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 50) begin @(negedge clk); n++; end
        if (!op_ready) begin
            chk("accept_timeout", 0, 1);
            op_valid = 1'b0;
            return;
        end
        model_push(o, int'(d), cyc + 1);
        @(posedge clk); #1;
        if (hold) begin
            op  = o + 2'(1 + $urandom_range(0, 2));
            din = W'($urandom);
            n = 0;
            @(negedge clk);
            while (!op_ready && n < 50) begin @(negedge clk); n++; end
        end
        op_valid = 1'b0;
    endtask

    task automatic settle_wait();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst = 1'b1; din = '0; op = LD; op_valid = 1'b0;
        din2 = '0; op2 = LD; op_valid2 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_acc", acc1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_ready", op_ready, 1);
        chk("rst_res_valid", rv1, 0);

        issue(LD, 4'd5, 1'b0);
        issue(AD, 4'd3, 1'b1);
        settle_wait();
        chk("ex_add_acc", acc1, 8);
        chk("ex_add_v", fv1, 1);
        chk("ex_add_c", fc1, 0);
        chk("ex_add_ovf", ovf1, 1);
        issue(SB, 4'd1, 1'b1);
        settle_wait();
        chk("ex_sub_acc", acc1, 7);
        chk("ex_sub_c", fc1, 1);
        chk("ex_sub_ovf", ovf1, 2);
        issue(LD, 4'd0, 1'b0);
        issue(SB, 4'd1, 1'b0);
        settle_wait();
        chk("ex_borrow_acc", acc1, 15);
        chk("ex_borrow_c", fc1, 0);
        issue(CL, 4'd9, 1'b1);
        settle_wait();
        chk("ex_clr_acc", acc1, 0);
        chk("ex_clr_ovf", ovf1, 2);

        for (int i = 0; i < 20; i++) begin
            issue(LD, 4'd7, 1'b0);
            issue(AD, 4'd7, 1'b0);
        end
        settle_wait();
        chk("ovf_saturated", ovf1, 15);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), W'($urandom), 1'($urandom));
        end
        settle_wait();

        // Reset while the subtract is in EXEC: no capture, no result.
        issue(LD, 4'd9, 1'b0);
        issue(SB, 4'd2, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("exec_rst_acc", acc1, 0);
        chk("exec_rst_a", a1, 0);
        chk("exec_rst_b", b1, 0);
        chk("exec_rst_m", m1, 0);
        chk("exec_rst_flags", {fc1, fv1}, 0);
        chk("exec_rst_ovf", ovf1, 0);
        chk("exec_rst_res_valid", rv1, 0);
        chk("exec_rst_ready", op_ready, 1);
        settle_wait();
        issue(AD, 4'd4, 1'b0);
        settle_wait();
        chk("post_rst_add", acc1, 4);

        // Slow instance: capture exactly SETTLE_CYC edges after accept.
        @(negedge clk);
        op2 = LD; din2 = 4'd6; op_valid2 = 1'b1;
        chk("slow_ready_load", op_ready2, 1);
        @(posedge clk); #1 op_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        op2 = AD; din2 = 4'd5; op_valid2 = 1'b1;
        chk("slow_ready_add", op_ready2, 1);
        t = cyc + 1;
        @(posedge clk); #1 op_valid2 = 1'b0;
        for (int k = 0; k <= SET2; k++) begin
            @(negedge clk);
            chk("slow_edge", cyc - t, k);
            chk("slow_acc", acc2, (k < SET2) ? 6 : 11);
            chk("slow_res_valid", rv2, (k == SET2) ? 1 : 0);
        end
        @(negedge clk);
        chk("slow_res_pulse_end", rv2, 0);

        settle_wait();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
